// File: rtl/nibble_add_pkg.sv
// Shared definitions for the nibble-serial adder: slice width, default size
// and the controller state encoding.
package nibble_add_pkg;

  localparam int SLICE_W     = 4;
  localparam int NIBBLES_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/add4_slice.sv
// Combinational 4-bit ripple adder slice; exposes the carry into bit 3 so the
// caller can derive signed overflow on the most significant slice.
module add4_slice
  import nibble_add_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               cin,
  output logic [SLICE_W-1:0] sum,
  output logic               cout,
  output logic               c3
);

  logic [SLICE_W:0] c_s;

  // Bitwise ripple through the slice
  always_comb begin
    c_s    = '0;
    sum    = '0;
    c_s[0] = cin;
    for (int i = 0; i < SLICE_W; i++) begin
      sum[i]   = a[i] ^ b[i] ^ c_s[i];
      c_s[i+1] = (a[i] & b[i]) | (c_s[i] & (a[i] ^ b[i]));
    end
  end

  assign cout = c_s[SLICE_W];
  assign c3   = c_s[SLICE_W-1];

endmodule

// File: rtl/nibble_serial_add_ctrl.sv
// Serial add/subtract controller: one shared 4-bit slice processes one nibble
// per clock, LSB first, and publishes the full result on completion.
module nibble_serial_add_ctrl
  import nibble_add_pkg::*;
#(
  parameter int NIBBLES = NIBBLES_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       sub,
  input  logic [SLICE_W*NIBBLES-1:0] a,
  input  logic [SLICE_W*NIBBLES-1:0] b,
  output logic                       busy,
  output logic                       done,
  output logic [SLICE_W*NIBBLES-1:0] s,
  output logic                       cout,
  output logic                       ovfl
);

  localparam int W     = SLICE_W * NIBBLES;
  localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  state_t             state_r;
  logic [IDX_W-1:0]   idx_r;
  logic               carry_r;
  logic [W-1:0]       a_r;
  logic [W-1:0]       b_r;
  logic [W-1:0]       work_r;
  logic [W-1:0]       work_next_s;
  logic [SLICE_W-1:0] sum_s;
  logic               slice_cout_s;
  logic               slice_c3_s;
  logic               last_s;

  add4_slice u_slice (
    .a    (a_r[SLICE_W*idx_r +: SLICE_W]),
    .b    (b_r[SLICE_W*idx_r +: SLICE_W]),
    .cin  (carry_r),
    .sum  (sum_s),
    .cout (slice_cout_s),
    .c3   (slice_c3_s)
  );

  assign last_s = (idx_r == IDX_W'(NIBBLES - 1));
  assign busy   = (state_r != IDLE);

  // Work register with the current slice merged in
  always_comb begin
    work_next_s                              = work_r;
    work_next_s[SLICE_W*idx_r +: SLICE_W]    = sum_s;
  end

  // Controller state, operand latches and published result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      idx_r   <= '0;
      carry_r <= 1'b0;
      a_r     <= '0;
      b_r     <= '0;
      work_r  <= '0;
      s       <= '0;
      cout    <= 1'b0;
      ovfl    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            // Subtraction is a + ~b + 1, with the +1 entering as the first carry
            a_r     <= a;
            b_r     <= sub ? ~b : b;
            carry_r <= sub;
            idx_r   <= '0;
            state_r <= RUN;
          end
        end
        RUN: begin
          carry_r <= slice_cout_s;
          work_r  <= work_next_s;
          if (last_s) begin
            s       <= work_next_s;
            cout    <= slice_cout_s;
            ovfl    <= slice_c3_s ^ slice_cout_s;
            done    <= 1'b1;
            state_r <= DONE;
          end else begin
            idx_r <= idx_r + IDX_W'(1);
          end
        end
        DONE: begin
          done    <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          done    <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule
